// File: rtl/slave_pkt_fifo_if.sv
// ---------------------------------------------------------------------------
// slave_pkt_fifo_if : channel-write and arbiter-stream signals of the packet slave
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface slave_pkt_fifo_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 6
);
    logic [DATA_W-1:0] chx_data_i;
    logic              chx_valid_i;
    logic              chx_ready_o;
    logic              slvx_en_i;
    logic [2:0]        slvx_pkglen_i;
    logic [AW:0]       slvx_margin_o;
    logic              slvx_req_o;
    logic              a2sx_ack_i;
    logic [DATA_W-1:0] slvx_data_o;
    logic              slvx_valid_o;
    logic              a2sx_rdy_i;
    logic              slvx_busy_o;

    modport slave (
        input  chx_data_i, chx_valid_i, slvx_en_i, slvx_pkglen_i, a2sx_ack_i, a2sx_rdy_i,
        output chx_ready_o, slvx_margin_o, slvx_req_o, slvx_data_o, slvx_valid_o, slvx_busy_o
    );

    modport master (
        output chx_data_i, chx_valid_i, slvx_en_i, slvx_pkglen_i, a2sx_ack_i, a2sx_rdy_i,
        input  chx_ready_o, slvx_margin_o, slvx_req_o, slvx_data_o, slvx_valid_o, slvx_busy_o
    );
endinterface

`default_nettype wire

// File: rtl/slave_pkt_fifo.sv
// ---------------------------------------------------------------------------
// slave_pkt_fifo : packet FIFO slave; requests the arbiter once a full packet is buffered.
// Optional completed-packet counter enabled by macro SLV_PKT_FIFO_PKTCNT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module slave_pkt_fifo #(
    parameter int DATA_W      = 32,
    parameter int AW          = 6,
    parameter int MAXLEN_CODE = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    slave_pkt_fifo_if.slave      bus
`ifdef SLV_PKT_FIFO_PKTCNT_EN
    ,
    output logic [15:0]          slvx_pktcnt_o
`endif
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [2:0]  MAXC    = 3'(MAXLEN_CODE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       len_q;
    logic [AW:0]       beat_cnt;
    logic [AW:0]       dec_len;
    logic [2:0]        code_c;
    logic              full;
    logic              wr_en;
    logic              rd_en;
    logic              last_beat;
    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        count     = wr_ptr - rd_ptr;
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        code_c    = (bus.slvx_pkglen_i > MAXC) ? MAXC : bus.slvx_pkglen_i;
        dec_len   = (AW+1)'(4) << code_c;
        wr_en     = bus.chx_valid_i && bus.chx_ready_o;
        rd_en     = bus.slvx_valid_o && bus.a2sx_rdy_i;
        last_beat = rd_en && (beat_cnt == len_q - 1'b1);
    end

    // Outputs are forced to their idle values while reset is held, not just after it.
    always_comb begin
        bus.chx_ready_o   = !full && bus.slvx_en_i && !rst_i;
        bus.slvx_margin_o = rst_i ? DEPTH_V : DEPTH_V - count;
        bus.slvx_req_o    = !rst_i && (state == REQ);
        bus.slvx_valid_o  = !rst_i && (state == SEND);
        bus.slvx_busy_o   = !rst_i && (state != IDLE);
        bus.slvx_data_o   = bus.slvx_valid_o ? mem[rd_ptr[AW-1:0]] : '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count >= dec_len) state_nxt = REQ;
            REQ:     if (bus.a2sx_ack_i)   state_nxt = SEND;
            SEND:    if (last_beat)        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= '0;
            len_q    <= (AW+1)'(4);
        end else begin
            state <= state_nxt;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            // Length is frozen for the whole packet once the request is raised.
            if (state == IDLE && state_nxt == REQ)
                len_q <= dec_len;
            if (state == REQ && bus.a2sx_ack_i)
                beat_cnt <= '0;
            else if (rd_en)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= bus.chx_data_i;
    end

`ifdef SLV_PKT_FIFO_PKTCNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            slvx_pktcnt_o <= '0;
        else if (last_beat)
            slvx_pktcnt_o <= slvx_pktcnt_o + 16'd1;
    end
`endif

endmodule

`default_nettype wire
